// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK levels, idle-fill byte.
// Used by i2c_slave and i2c_master.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_e;

  localparam logic       ACK       = 1'b0;
  localparam logic       NACK      = 1'b1;
  localparam logic [7:0] IDLE_FILL = 8'hFF;

endpackage

// File: rtl/i2c_line_filter.sv
// Bus line synchronizer, plus a 3-sample majority filter when
// I2C_SLAVE_GLITCH_FILTER_EN is defined. Resets to the idle bus level (1).
`timescale 1ns/1ps
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o
);

  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[N-2:0], line_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic       s;
  logic [1:0] hist_q;
  logic       maj_q;

  assign s = sync_q[N-1];

  // A single-cycle pulse never occupies two of the three taps at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= 2'b11;
      maj_q  <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], s};
      maj_q  <= (s & hist_q[0]) |
                (s & hist_q[1]) |
                (hist_q[0] & hist_q[1]);
    end
  end

  assign line_o = maj_q;
`else
  assign line_o = sync_q[N-1];
`endif

endmodule

// File: rtl/i2c_slave.sv
// I2C slave bridging bus writes/reads to FIFOs; open-drain SDA, SCL input only.
// Optional input glitch filtering via I2C_SLAVE_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clkIn,
  input  logic       rstIn,
  input  logic       sclIn,
  inout  wire        sdaBi,
  output logic [7:0] wrDataOut,
  output logic       wrFifoEnOut,
  input  logic       wrFullIn,
  input  logic [7:0] rdDataIn,
  input  logic       rdEmptyIn,
  output logic       rdFifoEnOut,
  output logic       busyOut
);

  logic scl_s;
  logic sda_s;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk_i (clkIn),
    .rst_i (rstIn),
    .line_i(sclIn),
    .line_o(scl_s)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk_i (clkIn),
    .rst_i (rstIn),
    .line_i(sdaBi),
    .line_o(sda_s)
  );

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       sda_q, sda_d;
  logic       busy_q, busy_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  logic       scl_prev_q;
  logic       sda_prev_q;

  logic       scl_rise;
  logic       scl_fall;
  logic       start_c;
  logic       stop_c;
  logic       load;
  logic [7:0] tx_byte;

  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign tx_byte  = rdEmptyIn ? IDLE_FILL : rdDataIn;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    ack_d     = ack_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    load      = 1'b0;
    if (stop_c) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (start_c) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      sda_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: ;
        ADDR: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (sh_q[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              sda_d   = ACK;
              busy_d  = 1'b1;
              rw_d    = sh_q[0];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              load = 1'b1;
            end else begin
              state_d = WR_BYTE;
              sda_d   = 1'b1;
              cnt_d   = 4'd0;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d = WR_ACK;
            if (!wrFullIn) begin
              wr_data_d = sh_q;
              wr_en_d   = 1'b1;
              sda_d     = ACK;
            end else begin
              sda_d     = NACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_d = WR_BYTE;
            sda_d   = 1'b1;
            cnt_d   = 4'd0;
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = RD_ACK;
              sda_d   = 1'b1;
            end else begin
              sda_d = sh_q[7];
              sh_d  = {sh_q[6:0], 1'b1};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_d = sda_s;
          end else if (scl_fall) begin
            if (ack_q == ACK) begin
              load = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Bit 7 goes straight onto the bus; the rest waits in the shifter.
    if (load) begin
      state_d = RD_BYTE;
      sda_d   = tx_byte[7];
      sh_d    = {tx_byte[6:0], 1'b1};
      cnt_d   = 4'd1;
      rd_en_d = ~rdEmptyIn;
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sh_q       <= 8'h00;
      rw_q       <= 1'b0;
      ack_q      <= NACK;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      wr_data_q  <= 8'h00;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign sdaBi       = sda_q ? 1'bz : 1'b0;
  assign wrDataOut   = wr_data_q;
  assign wrFifoEnOut = wr_en_q;
  assign rdFifoEnOut = rd_en_q;
  assign busyOut     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: directed vector table, corner-case
// sequences, and randomized transactions against a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda_oe;
  logic       wr_full;
  logic       rd_empty;
  logic [7:0] rd_data;
  wire  [7:0] wr_data;
  wire        wr_en;
  wire        rd_en;
  wire        busy;
  wire        sda;

  always #5 clk = ~clk;

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  i2c_slave dut (
    .clkIn      (clk),
    .rstIn      (rst),
    .sclIn      (scl),
    .sdaBi      (sda),
    .wrDataOut  (wr_data),
    .wrFifoEnOut(wr_en),
    .wrFullIn   (wr_full),
    .rdDataIn   (rd_data),
    .rdEmptyIn  (rd_empty),
    .rdFifoEnOut(rd_en),
    .busyOut    (busy)
  );

  typedef struct {
    logic [6:0]      addr;
    logic            rw;
    logic            full;
    int              n;
    int              fill;
    logic [2:0][7:0] d;
    logic            e_aack;
    logic            e_dack;
    logic [2:0][7:0] e_b;
    int              e_wr;
    int              e_pop;
    logic            e_busy;
  } vec_t;

  localparam int Q = 6;

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] wr_log[$];
  int         pops;
  logic       low_seen;

  // Bus/FIFO observer and first-word-fall-through read FIFO model.
  always @(negedge clk) begin
    if (wr_en) wr_log.push_back(wr_data);
    if (rd_en) begin
      pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (sda === 1'b0 && !m_sda_oe) low_seen = 1'b1;
    rd_empty = (fifo_q.size() == 0);
    rd_data  = rd_empty ? 8'h00 : fifo_q[0];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wq;
    repeat (Q) @(negedge clk);
  endtask

  task automatic start_c;
    m_sda_oe = 1'b0; wq;
    scl = 1'b1;      wq;
    m_sda_oe = 1'b1; wq;
    scl = 1'b0;      wq;
  endtask

  task automatic stop_c;
    m_sda_oe = 1'b1; wq;
    scl = 1'b1;      wq;
    m_sda_oe = 1'b0; wq;
    wq;
  endtask

  task automatic put_bit(input logic b);
    m_sda_oe = ~b; wq;
    scl = 1'b1;    wq; wq;
    scl = 1'b0;    wq;
  endtask

  task automatic get_bit(output logic b);
    m_sda_oe = 1'b0; wq;
    scl = 1'b1;      wq;
    b = sda;         wq;
    scl = 1'b0;      wq;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      get_bit(b);
      v = {v[6:0], b};
    end
    put_bit(nack);
  endtask

  function automatic vec_t mkv(
    input logic [6:0] addr, input logic rw, input logic full,
    input int n, input int fill, input logic [7:0] b0, input logic [7:0] b1,
    input logic aack, input logic dack, input logic [7:0] e0,
    input logic [7:0] e1, input int wr, input int pop, input logic bsy);
    vec_t v;
    v.addr = addr; v.rw = rw; v.full = full; v.n = n; v.fill = fill;
    v.d[0] = b0; v.d[1] = b1; v.d[2] = 8'h00;
    v.e_aack = aack; v.e_dack = dack;
    v.e_b[0] = e0; v.e_b[1] = e1; v.e_b[2] = 8'h00;
    v.e_wr = wr; v.e_pop = pop; v.e_busy = bsy;
    return v;
  endfunction

  // Transaction-level expectation: only a matching address is answered;
  // writes land unless full; reads pop what the FIFO holds, else 0xFF.
  function automatic vec_t model(input vec_t v);
    logic hit;
    logic wok;
    hit = (v.addr == 7'h50);
    wok = hit && !v.rw && !v.full;
    v.e_aack = !hit;
    v.e_busy = hit;
    v.e_dack = !wok;
    v.e_wr   = wok ? v.n : 0;
    v.e_pop  = (hit && v.rw) ? ((v.fill < v.n) ? v.fill : v.n) : 0;
    for (int i = 0; i < 3; i++) begin
      if (!v.rw) v.e_b[i] = v.d[i];
      else v.e_b[i] = (hit && i < v.fill) ? v.d[i] : 8'hFF;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic       a;
    logic [7:0] b;
    fifo_q.delete();
    for (int i = 0; i < v.fill; i++) fifo_q.push_back(v.d[i]);
    wr_full = v.full;
    repeat (2) @(negedge clk);
    wr_log.delete();
    pops = 0;
    low_seen = 1'b0;
    start_c;
    send_byte({v.addr, v.rw}, a);
    chk({tag, " addr_ack"}, a, v.e_aack);
    chk({tag, " busy_mid"}, busy, v.e_busy);
    for (int i = 0; i < v.n; i++) begin
      if (v.rw) begin
        recv_byte(i == v.n - 1, b);
        chk({tag, " rd_byte"}, b, v.e_b[i]);
      end else begin
        send_byte(v.d[i], a);
        chk({tag, " data_ack"}, a, v.e_dack);
      end
    end
    stop_c;
    repeat (4) @(negedge clk);
    chk({tag, " busy_end"}, busy, 0);
    chk({tag, " wr_count"}, wr_log.size(), v.e_wr);
    for (int i = 0; i < wr_log.size() && i < v.e_wr; i++)
      chk({tag, " wr_data"}, wr_log[i], v.e_b[i]);
    chk({tag, " rd_pops"}, pops, v.e_pop);
    if (v.e_aack) chk({tag, " sda_never_low"}, low_seen, 0);
  endtask

  initial begin
    #800us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[7];
    vec_t       v;
    logic       a;
    logic [6:0] ra;

    tbl[0] = mkv(7'h50, 0, 0, 2, 0, 8'h3C, 8'hC3,
                 0, 0, 8'h3C, 8'hC3, 2, 0, 1);
    tbl[1] = mkv(7'h51, 0, 0, 1, 0, 8'hAA, 8'h00,
                 1, 1, 8'hAA, 8'h00, 0, 0, 0);
    tbl[2] = mkv(7'h50, 1, 0, 2, 2, 8'h5A, 8'h96,
                 0, 0, 8'h5A, 8'h96, 0, 2, 1);
    tbl[3] = mkv(7'h50, 1, 0, 1, 0, 8'h00, 8'h00,
                 0, 0, 8'hFF, 8'h00, 0, 0, 1);
    tbl[4] = mkv(7'h50, 0, 1, 1, 0, 8'h11, 8'h00,
                 0, 1, 8'h11, 8'h00, 0, 0, 1);
    tbl[5] = mkv(7'h51, 1, 0, 1, 1, 8'h33, 8'h00,
                 1, 0, 8'hFF, 8'h00, 0, 0, 0);
    tbl[6] = mkv(7'h50, 1, 0, 2, 1, 8'hA5, 8'h00,
                 0, 0, 8'hA5, 8'hFF, 0, 1, 1);

    rst = 1'b1; scl = 1'b1; m_sda_oe = 1'b0; wr_full = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst wrDataOut", wr_data, 8'h00);
    chk("rst wrFifoEn", wr_en, 0);
    chk("rst rdFifoEn", rd_en, 0);
    chk("rst busy", busy, 0);
    chk("rst sda", sda, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst wrDataOut", wr_data, 8'h00);
    chk("post_rst strobes", {wr_en, rd_en}, 0);
    chk("post_rst busy", busy, 0);
    chk("post_rst sda", sda, 1);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Repeated START after 4 data bits drops the partial byte.
    wr_log.delete();
    start_c;
    send_byte(8'hA0, a);
    chk("rs first_addr_ack", a, 0);
    put_bit(1); put_bit(0); put_bit(1); put_bit(1);
    start_c;
    send_byte(8'hA0, a);
    chk("rs second_addr_ack", a, 0);
    send_byte(8'h77, a);
    chk("rs data_ack", a, 0);
    stop_c;
    repeat (4) @(negedge clk);
    chk("rs wr_count", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("rs wr_data", wr_log[0], 8'h77);

    // Reset while the slave is driving ACK releases SDA at once.
    wr_log.delete();
    start_c;
    for (int i = 7; i >= 0; i--) put_bit(i == 7 || i == 5);
    m_sda_oe = 1'b0; wq;
    scl = 1'b1; wq;
    chk("mid_rst ack_driven", sda, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst sda_released", sda, 1);
    chk("mid_rst busy", busy, 0);
    rst = 1'b0;
    wq;
    scl = 1'b0; wq;
    send_byte(8'h12, a);
    chk("mid_rst ignored_nack", a, 1);
    stop_c;
    repeat (4) @(negedge clk);
    chk("mid_rst wr_count", wr_log.size(), 0);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // One-cycle SDA low while SCL high must not look like START.
    repeat (4) @(negedge clk);
    m_sda_oe = 1'b1;
    @(negedge clk);
    m_sda_oe = 1'b0;
    wq;
    scl = 1'b0; wq;
    send_byte(8'hA0, a);
    chk("glitch no_start", a, 1);
    stop_c;
    repeat (4) @(negedge clk);
    chk("glitch busy", busy, 0);
`endif

    for (int k = 0; k < 20; k++) begin
      ra = 7'($urandom);
      if (ra == 7'h50) ra = 7'h51;
      v.addr = ($urandom_range(0, 3) != 0) ? 7'h50 : ra;
      v.rw   = 1'($urandom_range(0, 1));
      v.full = ($urandom_range(0, 3) == 0);
      v.n    = $urandom_range(1, 3);
      v.fill = $urandom_range(0, 3);
      for (int i = 0; i < 3; i++) v.d[i] = 8'($urandom);
      v = model(v);
      run_vec(v, $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
